// File: rtl/rv32c_mem_unit.sv
// Multi-cycle load/store unit for RV32C c.lw/c.sw; defining RV32C_SP_EN adds
// c.lwsp/c.swsp. Drives a word-addressed RAM through a ready handshake with a wait timeout.
module rv32c_mem_unit #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iVALID,
  input  logic [15:0]       iIR,
  input  logic [31:0]       iRS1,
  input  logic [31:0]       iRS2,
  output logic [4:0]        oRS1,
  output logic [4:0]        oRS2,
  output logic [4:0]        oRD,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oWB_EN,
  output logic [31:0]       oALU_OUT,
  output logic              oMISALIGN,
  output logic              oTIMEOUT,
  output logic              oILLEGAL,
  output logic              oRAM_CE,
  output logic              oRAM_RD,
  output logic              oRAM_WR,
  output logic [ADDR_W-1:0] oRAM_ADDR,
  output logic [31:0]       oRAM_WDATA,
  input  logic [31:0]       iRAM_DATA,
  input  logic              iRAM_READY
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [8:0] TMO     = 9'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       alu_q, alu_d;
  logic              load_q, load_d;
  logic              mis_q, mis_d, tmo_q, tmo_d, ill_q, ill_d;

  logic [1:0]  op;
  logic [2:0]  f3;
  logic        legal, is_load;
  logic [31:0] imm, ea;

  assign op = iIR[1:0];
  assign f3 = iIR[15:13];

  always_comb begin
    legal   = 1'b0;
    is_load = 1'b0;
    imm     = {25'b0, iIR[5], iIR[12:10], iIR[6], 2'b00};
    oRS1    = {2'b01, iIR[9:7]};
    oRS2    = {2'b01, iIR[4:2]};
    oRD     = {2'b01, iIR[4:2]};
    if (op == 2'b00 && f3 == 3'b010) begin
      legal   = 1'b1;
      is_load = 1'b1;
    end else if (op == 2'b00 && f3 == 3'b110) begin
      legal = 1'b1;
    end
`ifdef RV32C_SP_EN
    // Stack-pointer forms: base is always x2, register fields are full 5 bits.
    else if (op == 2'b10 && f3 == 3'b010) begin
      oRS1    = 5'd2;
      oRD     = iIR[11:7];
      imm     = {24'b0, iIR[3:2], iIR[12], iIR[6:4], 2'b00};
      is_load = 1'b1;
      legal   = (iIR[11:7] != 5'd0);
    end else if (op == 2'b10 && f3 == 3'b110) begin
      oRS1  = 5'd2;
      oRS2  = iIR[6:2];
      imm   = {24'b0, iIR[8:7], iIR[12:9], 2'b00};
      legal = 1'b1;
    end
`endif
  end

  assign ea = iRS1 + imm;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    alu_d   = alu_q;
    load_d  = load_q;
    mis_d   = 1'b0;
    tmo_d   = 1'b0;
    ill_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iVALID) begin
          if (!legal) begin
            ill_d = 1'b1;
          end else if (ea[1:0] != 2'b00) begin
            mis_d = 1'b1;
          end else begin
            addr_d  = ea[ADDR_W+1:2];
            wdata_d = iRS2;
            load_d  = is_load;
            cnt_d   = 8'd0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 8'd1;
        // Ready on the final allowed cycle still wins over the timeout.
        if (iRAM_READY) begin
          if (load_q) alu_d = iRAM_DATA;
          state_d = S_DONE;
        end else if ({1'b0, cnt_q} + 9'd1 >= TMO) begin
          tmo_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      alu_q   <= 32'd0;
      load_q  <= 1'b0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      alu_q   <= alu_d;
      load_q  <= load_d;
      mis_q   <= mis_d;
      tmo_q   <= tmo_d;
      ill_q   <= ill_d;
    end
  end

  assign oBUSY      = (state_q != S_IDLE);
  assign oDONE      = (state_q == S_DONE);
  assign oWB_EN     = (state_q == S_DONE) && load_q;
  assign oALU_OUT   = alu_q;
  assign oMISALIGN  = mis_q;
  assign oTIMEOUT   = tmo_q;
  assign oILLEGAL   = ill_q;
  assign oRAM_CE    = (state_q == S_ISSUE);
  assign oRAM_RD    = (state_q == S_ISSUE) && load_q;
  assign oRAM_WR    = (state_q == S_ISSUE) && !load_q;
  assign oRAM_ADDR  = addr_q;
  assign oRAM_WDATA = wdata_q;

endmodule

// File: tb/tb_rv32c_mem_unit.sv
// Directed bench for rv32c_mem_unit: loads, stores, waits, timeout, errors,
// back-to-back issue and reset during an access.
module tb_rv32c_mem_unit;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iVALID = 1'b0;
  logic [15:0] iIR = 16'h0;
  logic [31:0] iRS1 = 32'h0, iRS2 = 32'h0, iRAM_DATA = 32'h0;
  logic        iRAM_READY = 1'b0;
  logic [4:0]  oRS1, oRS2, oRD;
  logic        oBUSY, oDONE, oWB_EN, oMISALIGN, oTIMEOUT, oILLEGAL;
  logic        oRAM_CE, oRAM_RD, oRAM_WR;
  logic [31:0] oALU_OUT, oRAM_WDATA;
  logic [7:0]  oRAM_ADDR;

  int checks = 0;
  int errors = 0;

  // results of the most recent access
  int          k_evt, n_rd, n_wr;
  logic [31:0] a_addr, a_wdata, e_alu;
  logic        e_done, e_wb, e_tmo, e_mis, e_ill, e_busy;
  logic [4:0]  e_rd;

  rv32c_mem_unit #(.ADDR_W(8), .TIMEOUT(15)) dut (
    .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .iIR(iIR), .iRS1(iRS1), .iRS2(iRS2),
    .oRS1(oRS1), .oRS2(oRS2), .oRD(oRD), .oBUSY(oBUSY), .oDONE(oDONE), .oWB_EN(oWB_EN),
    .oALU_OUT(oALU_OUT), .oMISALIGN(oMISALIGN), .oTIMEOUT(oTIMEOUT), .oILLEGAL(oILLEGAL),
    .oRAM_CE(oRAM_CE), .oRAM_RD(oRAM_RD), .oRAM_WR(oRAM_WR), .oRAM_ADDR(oRAM_ADDR),
    .oRAM_WDATA(oRAM_WDATA), .iRAM_DATA(iRAM_DATA), .iRAM_READY(iRAM_READY)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #500000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic [31:0] status();
    return 32'({oBUSY, oDONE, oWB_EN, oMISALIGN, oTIMEOUT, oILLEGAL, oRAM_CE, oRAM_RD, oRAM_WR});
  endfunction

  // Present one instruction for a single cycle, assert READY on ISSUE cycle
  // wait_n+1, and stop at the first done or error pulse (k_evt = cycles after accept edge).
  task automatic access(input logic [15:0] ir, input logic [31:0] rs1, input logic [31:0] rs2,
                        input int wait_n, input logic [31:0] rdata);
    iIR = ir; iRS1 = rs1; iRS2 = rs2; iRAM_DATA = rdata; iVALID = 1'b1;
    k_evt = 0; n_rd = 0; n_wr = 0; a_addr = 32'h0; a_wdata = 32'h0;
    e_done = 0; e_wb = 0; e_tmo = 0; e_mis = 0; e_ill = 0; e_busy = 0; e_alu = 0; e_rd = 0;
    tick();
    iVALID = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (oDONE || oTIMEOUT || oMISALIGN || oILLEGAL) begin
        k_evt = k; e_done = oDONE; e_wb = oWB_EN; e_tmo = oTIMEOUT; e_mis = oMISALIGN;
        e_ill = oILLEGAL; e_busy = oBUSY; e_alu = oALU_OUT; e_rd = oRD;
        break;
      end
      if (oRAM_RD) n_rd++;
      if (oRAM_WR) n_wr++;
      if (oRAM_CE && (n_rd + n_wr) == 1) begin
        a_addr = 32'(oRAM_ADDR); a_wdata = oRAM_WDATA;
      end
      iRAM_READY = oRAM_CE && ((n_rd + n_wr) == wait_n + 1);
      tick();
    end
    iRAM_READY = 1'b0;
  endtask

  initial begin
    tick(); tick();
    iRST = 1'b0;
    check("rst_status", status(), 32'h0);
    check("rst_alu", oALU_OUT, 32'h0);
    check("rst_addr", 32'(oRAM_ADDR), 32'h0);
    check("rst_wdata", oRAM_WDATA, 32'h0);

    // c.lw x9,4(x8), ready immediately
    access(16'h4044, 32'h10, 32'h0, 0, 32'hDEADBEEF);
    check("lw_lat", 32'(k_evt), 32'd2);
    check("lw_nrd", 32'(n_rd), 32'd1);
    check("lw_nwr", 32'(n_wr), 32'd0);
    check("lw_addr", a_addr, 32'h05);
    check("lw_done_wb", {30'b0, e_done, e_wb}, 32'h3);
    check("lw_rd", 32'(e_rd), 32'd9);
    check("lw_alu", e_alu, 32'hDEADBEEF);

    // back-to-back: request during DONE is ignored, accepted one cycle later
    iVALID = 1'b1;
    tick();
    check("b2b_idle", status(), 32'h0);
    tick();
    check("b2b_issue_ce", 32'(oRAM_CE), 32'd1);
    iVALID = 1'b0; iRAM_READY = 1'b1; iRAM_DATA = 32'h0BADCAFE;
    tick();
    iRAM_READY = 1'b0;
    check("b2b_done", 32'(oDONE), 32'd1);
    check("b2b_alu", oALU_OUT, 32'h0BADCAFE);
    tick();

    // c.sw x9,8(x8), three wait cycles
    access(16'hC404, 32'h20, 32'h12345678, 3, 32'h0);
    check("sw_rs1", 32'(oRS1), 32'd8);
    check("sw_rs2", 32'(oRS2), 32'd9);
    check("sw_lat", 32'(k_evt), 32'd5);
    check("sw_nwr", 32'(n_wr), 32'd4);
    check("sw_nrd", 32'(n_rd), 32'd0);
    check("sw_addr", a_addr, 32'h0A);
    check("sw_wdata", a_wdata, 32'h12345678);
    check("sw_done_wb", {30'b0, e_done, e_wb}, 32'h2);
    check("sw_alu_kept", e_alu, 32'h0BADCAFE);
    tick();

    // timeout: READY never comes
    access(16'h4044, 32'h10, 32'h0, 100, 32'h55555555);
    check("tmo_lat", 32'(k_evt), 32'd16);
    check("tmo_nrd", 32'(n_rd), 32'd15);
    check("tmo_flags", {29'b0, e_tmo, e_done, e_busy}, 32'h4);
    check("tmo_alu_kept", e_alu, 32'h0BADCAFE);
    tick();
    check("tmo_pulse_end", status(), 32'h0);

    // READY on the 15th ISSUE cycle still succeeds
    access(16'h4044, 32'h10, 32'h0, 14, 32'h13572468);
    check("tmo_edge_lat", 32'(k_evt), 32'd16);
    check("tmo_edge_flags", {30'b0, e_done, e_tmo}, 32'h2);
    check("tmo_edge_alu", e_alu, 32'h13572468);
    tick();

    // misaligned c.lw
    access(16'h4044, 32'h11, 32'h0, 0, 32'h0);
    check("mis_lat", 32'(k_evt), 32'd1);
    check("mis_flags", {29'b0, e_mis, e_ill, e_busy}, 32'h4);
    check("mis_strobes", 32'(n_rd + n_wr), 32'd0);
    tick();
    check("mis_pulse_end", status(), 32'h0);

    // all-zero encoding is illegal
    access(16'h0000, 32'h10, 32'h0, 0, 32'h0);
    check("ill_lat", 32'(k_evt), 32'd1);
    check("ill_flags", {29'b0, e_ill, e_mis, e_done}, 32'h4);
    tick();

    // c.lwsp x1,0(sp)
    access(16'h4082, 32'h40, 32'h0, 0, 32'hA5A5A5A5);
`ifdef RV32C_SP_EN
    check("lwsp_rs1", 32'(oRS1), 32'd2);
    check("lwsp_lat", 32'(k_evt), 32'd2);
    check("lwsp_addr", a_addr, 32'h10);
    check("lwsp_rd", 32'(e_rd), 32'd1);
    check("lwsp_alu", e_alu, 32'hA5A5A5A5);
`else
    check("lwsp_ill", 32'(e_ill), 32'd1);
    check("lwsp_lat", 32'(k_evt), 32'd1);
    check("lwsp_strobes", 32'(n_rd + n_wr), 32'd0);
`endif
    tick();

    // reset in the middle of ISSUE abandons the access
    iIR = 16'h4044; iRS1 = 32'h10; iVALID = 1'b1;
    tick();
    iVALID = 1'b0;
    check("rsti_ce", 32'(oRAM_CE), 32'd1);
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    check("rsti_status", status(), 32'h0);
    check("rsti_alu", oALU_OUT, 32'h0);
    check("rsti_addr", 32'(oRAM_ADDR), 32'h0);
    tick();
    check("rsti_no_done", status(), 32'h0);

    access(16'h4044, 32'h10, 32'h0, 1, 32'h600DF00D);
    check("post_rst_lat", 32'(k_evt), 32'd3);
    check("post_rst_alu", e_alu, 32'h600DF00D);
    check("post_rst_wb", 32'(e_wb), 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
